// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b, LSB first) behind a start/done handshake.
// Optional signed overflow flag is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] d_next;
    logic             load;

`ifdef SERIAL_SUB_OVF_EN
    logic [1:0]       msb;
`endif

    // Full-subtractor cell on the current LSBs; the new difference bit enters d_sh from the top.
    always_comb begin
        d_bit   = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        d_next  = {d_bit, d_sh[WIDTH-1:1]};
        load    = start && ((state == IDLE) || (state == DONE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            d_sh   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
            msb    <= 2'b00;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= d_next;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff   <= d_next;
                        borrow <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf    <= (msb[1] != msb[0]) && (d_bit != msb[1]);
`endif
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase

            // A start in IDLE or DONE overrides the state update above; start in RUN is ignored.
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                d_sh  <= '0;
                br    <= 1'b0;
                cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                msb   <= {a[WIDTH-1], b[WIDTH-1]};
`endif
                state <= RUN;
                busy  <= 1'b1;
            end
        end
    end

`ifndef SERIAL_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

endmodule
